pc_sequencer: RTL
=================

# pc_sequencer

Multicycle program-counter sequencer for the core's PC path. Walks each instruction through fetch, decode and execute, and drives the 2-bit select of the PC source multiplexer and the PC write enable. Redirects to a trap vector on illegal instructions or fetch time-outs, and counts retired instructions. Sits between the main control unit, instruction memory and the PC register/mux.

## Interface
- `TIMEOUT`, default 15: fetch wait cycles tolerated before a time-out trap (≥2).
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `mem_ready` in 1: instruction memory returns data this cycle.
- `is_branch` in 1: decoded conditional branch. Sampled in EXEC.
- `is_jal` in 1: decoded JAL. Sampled in EXEC.
- `is_jalr` in 1: decoded JALR. Sampled in EXEC.
- `illegal` in 1: decoded illegal opcode. Sampled in EXEC.
- `branch_taken` in 1: ALU compare result. Sampled in EXEC.
- `stall` in 1: hold EXEC, e.g. for a data-memory wait.
- `pc_sel` out 2: PC mux select.
  - 0 = PC+4
  - 1 = PC+imm (branch/JAL)
  - 2 = ALU result (JALR)
  - 3 = fixed trap/boot vector
- `pc_write` out 1: PC register load enable.
- `fetch_req` out 1: instruction memory request.
- `ir_write` out 1: instruction register load.
- `trap_cause` out 2: 0 none, 1 illegal, 2 fetch time-out. Sticky until the next trap or reset.
- `retired` out CNT_W: retired-instruction count.

## Operation
States: RST, BOOT, FETCH, DECODE, EXEC, TRAP.

- **RST:** entered asynchronously while `rst_n`=0.
  - All outputs 0; `retired`=0; `trap_cause`=0; time-out counter 0.
  - First rising edge with `rst_n`=1 → BOOT.
- **BOOT:** `pc_sel`=3, `pc_write`=1 for one cycle (loads the boot vector) → FETCH.
- **FETCH:** `fetch_req`=1; `pc_sel` is 0 and `pc_write` is 0.
  - `mem_ready`=1: `ir_write`=1 in the same cycle; time-out counter cleared → DECODE.
  - `mem_ready`=0: time-out counter increments. When the counter equals `TIMEOUT`-1 and `mem_ready`=0 → TRAP with cause 2.
- **DECODE:** one cycle, no outputs asserted → EXEC.
- **EXEC:** `pc_sel`/`pc_write` are combinational from the inputs (Mealy).
  - `stall`=1 has absolute priority: `pc_write`=0, `pc_sel`=0, stay in EXEC.
  - Otherwise, priority is illegal > is_jalr > is_jal > (is_branch & branch_taken) > sequential:
    - `illegal` → TRAP with cause 1; `pc_write`=0 this cycle.
    - `is_jalr` → `pc_sel`=2, `pc_write`=1.
    - `is_jal`, or `is_branch` with `branch_taken` → `pc_sel`=1, `pc_write`=1.
    - Otherwise (including a not-taken branch) → `pc_sel`=0, `pc_write`=1.
  - Every non-trap exit increments `retired` (wraps modulo 2^CNT_W) → FETCH.
- **TRAP:** `pc_sel`=3, `pc_write`=1 for one cycle; `trap_cause` is already updated on entry; `retired` unchanged → FETCH.
- Multiple class inputs asserted together resolve strictly by the priority above.

## Timing
- Non-stalled instruction: 3 cycles (FETCH with immediate `mem_ready`, DECODE, EXEC); fetch adds one cycle per `mem_ready`=0 cycle.
- Trap adds exactly 1 cycle (TRAP).
- After reset release: BOOT in the first cycle, FETCH in the second.
- `retired` and `trap_cause` update on the clock edge leaving EXEC or entering TRAP.
- Reset asserted mid-instruction: immediate return to RST; no partial `pc_write`, and `retired` clears.
- Time-out counter is reset on every FETCH entry, so it never carries across instructions.

## Test plan
- **Reset and boot:** hold `rst_n`=0 for 3 cycles, then release. Required: all outputs 0 during reset; cycle 1 shows `pc_sel`=3 with `pc_write`=1; cycle 2 shows `fetch_req`=1.
- **Sequential flow:** 4 ALU instructions with `mem_ready` high. Required: each EXEC has `pc_sel`=0 and `pc_write`=1, period is 3 cycles, and `retired`=4.
- **Control flow:** taken branch → `pc_sel`=1. Not-taken branch → `pc_sel`=0. JALR with `is_jal` also high → `pc_sel`=2. Required: `retired` increments on each.
- **Stall:** `stall` high for 5 EXEC cycles, then JAL. Required: `pc_write`=0 for 5 cycles, then `pc_sel`=1 with `pc_write`=1.
- **Traps:**
  - `illegal`=1 with `is_jal`=1 → TRAP, `pc_sel`=3, `trap_cause`=1, `retired` unchanged.
  - `mem_ready` held low with `TIMEOUT`=15 → TRAP after 15 FETCH cycles, `trap_cause`=2.
- **Wrap and reset:** with `CNT_W`=4, retire 17 instructions → `retired`=1. Then assert `rst_n` low during DECODE → outputs 0 and `retired`=0 immediately.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_sequencer_if
//
// Purpose: bundles the signals between the PC sequencer and its neighbours
// (main control unit, instruction memory, PC register/mux) into one port.
//
// Signals:
//   mem_ready    instruction memory returns data this cycle
//   is_branch    decoded conditional branch          (sampled in EXEC)
//   is_jal       decoded JAL                         (sampled in EXEC)
//   is_jalr      decoded JALR                        (sampled in EXEC)
//   illegal      decoded illegal opcode              (sampled in EXEC)
//   branch_taken ALU compare result                  (sampled in EXEC)
//   stall        hold EXEC (e.g. data-memory wait)
//   pc_sel       PC mux select: 0 PC+4, 1 PC+imm, 2 ALU, 3 trap/boot vector
//   pc_write     PC register load enable
//   fetch_req    instruction memory request
//   ir_write     instruction register load
//   trap_cause   0 none, 1 illegal, 2 fetch time-out (sticky)
//   retired      retired-instruction count
//
// Modports:
//   master  environment side (drives status/decode inputs, observes control)
//   slave   sequencer side
// -----------------------------------------------------------------------------
interface pc_sequencer_if #(
   parameter int CNT_W = 16
);
   logic             mem_ready;
   logic             is_branch;
   logic             is_jal;
   logic             is_jalr;
   logic             illegal;
   logic             branch_taken;
   logic             stall;
   logic [1:0]       pc_sel;
   logic             pc_write;
   logic             fetch_req;
   logic             ir_write;
   logic [1:0]       trap_cause;
   logic [CNT_W-1:0] retired;

   modport master (
      output mem_ready, is_branch, is_jal, is_jalr, illegal, branch_taken, stall,
      input  pc_sel, pc_write, fetch_req, ir_write, trap_cause, retired
   );

   modport slave (
      input  mem_ready, is_branch, is_jal, is_jalr, illegal, branch_taken, stall,
      output pc_sel, pc_write, fetch_req, ir_write, trap_cause, retired
   );
endinterface : pc_sequencer_if

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Purpose: multicycle program-counter sequencer. Walks each instruction through
// FETCH -> DECODE -> EXEC, drives the PC source select and PC write enable,
// redirects to the trap vector on illegal instructions or fetch time-outs, and
// counts retired instructions.
//
// Parameters:
//   TIMEOUT  fetch wait cycles tolerated before a time-out trap (>= 2)
//   CNT_W    width of the retired-instruction counter
//
// Ports:
//   clk      single clock, rising edge
//   rst_n    asynchronous active-low reset
//   bus      pc_sequencer_if.slave (decode/status inputs, PC control outputs)
//
// Output timing: control outputs are decoded from the current state and, in
// FETCH and EXEC, also from the live inputs (ir_write follows mem_ready,
// pc_sel/pc_write follow the EXEC decode). retired and trap_cause are
// registers.
// -----------------------------------------------------------------------------
module pc_sequencer #(
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   pc_sequencer_if.slave   bus
);

   typedef enum logic [2:0] {
      S_RST,
      S_BOOT,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_TRAP
   } state_e;

   typedef enum logic [1:0] {
      SEL_SEQ = 2'd0,   // PC + 4
      SEL_REL = 2'd1,   // PC + imm (branch / JAL)
      SEL_ALU = 2'd2,   // ALU result (JALR)
      SEL_VEC = 2'd3    // fixed trap / boot vector
   } pc_sel_e;

   typedef enum logic [1:0] {
      CAUSE_NONE    = 2'd0,
      CAUSE_ILLEGAL = 2'd1,
      CAUSE_TIMEOUT = 2'd2
   } cause_e;

   // Counter only has to reach TIMEOUT-1.
   localparam int              TO_W    = $clog2(TIMEOUT);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   state_e           state_q,   state_d;
   logic [TO_W-1:0]  to_cnt_q,  to_cnt_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   cause_e           cause_q,   cause_d;

   pc_sel_e          pc_sel;
   logic             pc_write;
   logic             fetch_req;
   logic             ir_write;

   // --------------------------------------------------------------------------
   // Next-state and output decode
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a default first so no path
      // leaves one unassigned, which would otherwise infer a latch.
      state_d   = state_q;
      to_cnt_d  = to_cnt_q;
      retired_d = retired_q;
      cause_d   = cause_q;
      pc_sel    = SEL_SEQ;
      pc_write  = 1'b0;
      fetch_req = 1'b0;
      ir_write  = 1'b0;

      unique case (state_q)
         S_RST: begin
            state_d = S_BOOT;
         end

         S_BOOT: begin
            pc_sel   = SEL_VEC;
            pc_write = 1'b1;
            to_cnt_d = '0;
            state_d  = S_FETCH;
         end

         S_FETCH: begin
            fetch_req = 1'b1;
            if (bus.mem_ready) begin
               ir_write = 1'b1;
               to_cnt_d = '0;
               state_d  = S_DECODE;
            end else if (to_cnt_q == TO_LAST) begin
               // TIMEOUT consecutive cycles without data: give up on this fetch.
               cause_d  = CAUSE_TIMEOUT;
               to_cnt_d = '0;
               state_d  = S_TRAP;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end

         S_DECODE: begin
            state_d = S_EXEC;
         end

         S_EXEC: begin
            if (bus.stall) begin
               // Hold: PC untouched, decode inputs ignored.
               state_d = S_EXEC;
            end else if (bus.illegal) begin
               // The trap vector is loaded in TRAP, not here.
               cause_d = CAUSE_ILLEGAL;
               state_d = S_TRAP;
            end else begin
               pc_write = 1'b1;
               if (bus.is_jalr) begin
                  pc_sel = SEL_ALU;
               end else if (bus.is_jal || (bus.is_branch && bus.branch_taken)) begin
                  pc_sel = SEL_REL;
               end else begin
                  pc_sel = SEL_SEQ;
               end
               retired_d = retired_q + CNT_W'(1);
               to_cnt_d  = '0;
               state_d   = S_FETCH;
            end
         end

         S_TRAP: begin
            pc_sel   = SEL_VEC;
            pc_write = 1'b1;
            to_cnt_d = '0;
            state_d  = S_FETCH;
         end

         default: begin
            state_d = S_RST;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // State registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_RST;
         to_cnt_q  <= '0;
         retired_q <= '0;
         cause_q   <= CAUSE_NONE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values, independent of statement order.
         state_q   <= state_d;
         to_cnt_q  <= to_cnt_d;
         retired_q <= retired_d;
         cause_q   <= cause_d;
      end
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   assign bus.pc_sel     = pc_sel;
   assign bus.pc_write   = pc_write;
   assign bus.fetch_req  = fetch_req;
   assign bus.ir_write   = ir_write;
   assign bus.trap_cause = cause_q;
   assign bus.retired    = retired_q;

endmodule : pc_sequencer
